// File: rtl/arc4_pkg.sv
// arc4_pkg: shared FSM states and sizing constants for the ARC4 encryptor.
package arc4_pkg;
    typedef enum logic [2:0] {IDLE, INIT, KSA, RDLEN, PRGA, DONE} state_e;
    localparam int SBOX_SIZE = 256;
    localparam int DEFAULT_KEY_BYTES = 3;
endpackage

// File: rtl/arc4_sbox_ram.sv
// arc4_sbox_ram: 256x8 single-port synchronous RAM holding the ARC4 state S.
module arc4_sbox_ram
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr,
    input  logic [7:0] wrdata,
    input  logic       wren,
    output logic [7:0] rddata
);
    logic [7:0] mem_q [SBOX_SIZE];

    always_ff @(posedge clk) begin
        if (wren) mem_q[addr] <= wrdata;
        rddata <= mem_q[addr];
    end
endmodule

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: reads a length-prefixed plaintext buffer and writes the ARC4
// ciphertext buffer, copying the length byte through unencrypted.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = DEFAULT_KEY_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);
    localparam logic [7:0] KLAST = 8'(KEY_BYTES - 1);

    state_e state_q, state_d;
    logic [2:0] ph_q, ph_d;
    logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
    logic [7:0] si_q, si_d, sj_q, sj_d, kidx_q, kidx_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d, key_sh;
    logic [7:0] ct_addr_q, ct_addr_d, ct_wrdata_q, ct_wrdata_d;
    logic ct_wren_q, ct_wren_d;
    logic [7:0] s_addr, s_wrdata, s_rddata, key_byte;
    logic s_wren;

    arc4_sbox_ram u_sbox (
        .clk    (clk),
        .addr   (s_addr),
        .wrdata (s_wrdata),
        .wren   (s_wren),
        .rddata (s_rddata)
    );

    // Key byte 0 sits in the top byte, so shift the selected byte up to the top.
    assign key_sh = key_q << (8 * int'(kidx_q));
    assign key_byte = key_sh[8*KEY_BYTES-1 -: 8];

    assign rdy = state_q == IDLE;
    assign pt_addr = k_q;
    assign ct_addr = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren = ct_wren_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            len_q       <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            kidx_q      <= '0;
            key_q       <= '0;
            ct_addr_q   <= '0;
            ct_wrdata_q <= '0;
            ct_wren_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            len_q       <= len_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            kidx_q      <= kidx_d;
            key_q       <= key_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            ct_wren_q   <= ct_wren_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        len_d       = len_q;
        si_d        = si_q;
        sj_d        = sj_q;
        kidx_d      = kidx_q;
        key_d       = key_q;
        ct_addr_d   = ct_addr_q;
        ct_wrdata_d = ct_wrdata_q;
        ct_wren_d   = 1'b0;
        s_addr      = i_q;
        s_wrdata    = i_q;
        s_wren      = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    key_d   = key;
                    i_d     = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                s_wren = 1'b1;
                i_d    = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    j_d     = '0;
                    kidx_d  = '0;
                    ph_d    = '0;
                    state_d = KSA;
                end
            end
            // Four cycles per i: read S[i], read S[j], write S[i], write S[j].
            KSA: begin
                case (ph_q)
                    3'd0: ph_d = 3'd1;
                    3'd1: begin
                        si_d   = s_rddata;
                        j_d    = j_q + s_rddata + key_byte;
                        s_addr = j_q + s_rddata + key_byte;
                        ph_d   = 3'd2;
                    end
                    3'd2: begin
                        s_wren   = 1'b1;
                        s_wrdata = s_rddata;
                        ph_d     = 3'd3;
                    end
                    default: begin
                        s_addr   = j_q;
                        s_wrdata = si_q;
                        s_wren   = 1'b1;
                        ph_d     = '0;
                        i_d      = i_q + 8'd1;
                        kidx_d   = kidx_q == KLAST ? 8'd0 : kidx_q + 8'd1;
                        if (i_q == 8'hFF) begin
                            k_d     = '0;
                            state_d = RDLEN;
                        end
                    end
                endcase
            end
            RDLEN: begin
                if (ph_q == 3'd0) begin
                    ph_d = 3'd1;
                end else begin
                    len_d       = pt_rddata;
                    ct_wren_d   = 1'b1;
                    ct_addr_d   = '0;
                    ct_wrdata_d = pt_rddata;
                    k_d         = 8'd1;
                    i_d         = '0;
                    j_d         = '0;
                    ph_d        = '0;
                    state_d     = pt_rddata <= 8'd1 ? DONE : PRGA;
                end
            end
            // Six cycles per byte; pt[k] is addressed for the whole step.
            PRGA: begin
                case (ph_q)
                    3'd0: begin
                        s_addr = i_q + 8'd1;
                        i_d    = i_q + 8'd1;
                        ph_d   = 3'd1;
                    end
                    3'd1: begin
                        si_d   = s_rddata;
                        j_d    = j_q + s_rddata;
                        s_addr = j_q + s_rddata;
                        ph_d   = 3'd2;
                    end
                    3'd2: begin
                        sj_d     = s_rddata;
                        s_wren   = 1'b1;
                        s_wrdata = s_rddata;
                        ph_d     = 3'd3;
                    end
                    3'd3: begin
                        s_addr   = j_q;
                        s_wrdata = si_q;
                        s_wren   = 1'b1;
                        ph_d     = 3'd4;
                    end
                    3'd4: begin
                        s_addr = si_q + sj_q;
                        ph_d   = 3'd5;
                    end
                    default: begin
                        ct_wren_d   = 1'b1;
                        ct_addr_d   = k_q;
                        ct_wrdata_d = pt_rddata ^ s_rddata;
                        k_d         = k_q + 8'd1;
                        ph_d        = '0;
                        if (k_q == len_q - 8'd1) state_d = DONE;
                    end
                endcase
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: directed ARC4 runs; expected ct writes are queued at launch
// and a negedge monitor pops and compares every write the DUT makes.
module tb_arc4_encrypt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic rdy;
    logic [23:0] key = '0;
    logic [7:0] pt_addr, pt_rddata, ct_addr, ct_wrdata;
    logic ct_wren;
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [15:0] exp_q [$];
    int nchk = 0;
    int nfail = 0;

    arc4_encrypt dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

    task automatic chk(input string nm, input int got, input int want);
        nchk++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (ct_wren) begin
            ct_mem[ct_addr] = ct_wrdata;
            if (exp_q.size() == 0) chk("unexpected_write", {ct_addr, ct_wrdata}, -1);
            else chk("ct_write{addr,data}", {ct_addr, ct_wrdata}, exp_q.pop_front());
        end
    end

    task automatic model(input logic [23:0] k);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] i, j, t, len;
        len = pt_mem[0];
        kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
        exp_q.push_back({8'h00, len});
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = j + s[n] + kb[n % 3];
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int n = 1; n < int'(len); n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            exp_q.push_back({8'(n), pt_mem[n] ^ s[t]});
        end
    endtask

    task automatic go(input logic [23:0] k);
        int c = 0;
        while (!rdy && c < 5000) begin @(posedge clk); #1; c++; end
        key = k; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int c = 0;
        while (!rdy && c < 5000) begin @(posedge clk); #1; c++; end
        chk("rdy_after_run", int'(rdy), 1);
        if (c > bound) chk("latency_cycles", c, bound);
        else chk("latency_within_bound", 1, 1 - int'(c > bound));
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic load_key_vec();
        logic [7:0] txt [10] = '{8'h0A, "P", "l", "a", "i", "n", "t", "e", "x", "t"};
        for (int n = 0; n < 10; n++) pt_mem[n] = txt[n];
    endtask

    task automatic push_key_vec();
        logic [7:0] c [10] = '{8'h0A, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int n = 0; n < 10; n++) exp_q.push_back({8'(n), c[n]});
    endtask

    initial begin
        logic [7:0] orig [8] = '{8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'hFF};
        logic [23:0] rk;
        for (int n = 0; n < 256; n++) pt_mem[n] = '0;
        #12;
        chk("reset_rdy", int'(rdy), 1);
        chk("reset_ct_wren", int'(ct_wren), 0);
        chk("reset_ct_addr", int'(ct_addr), 0);
        chk("reset_ct_wrdata", int'(ct_wrdata), 0);
        chk("reset_pt_addr", int'(pt_addr), 0);
        @(posedge clk); #1; rst = 1'b0;

        // Known vector
        load_key_vec(); push_key_vec();
        go(24'h4B6579);
        chk("rdy_falls", int'(rdy), 0);
        wait_done(256 + 5*256 + 6*10 + 8);

        // Round trip
        for (int n = 0; n < 8; n++) pt_mem[n] = orig[n];
        model(24'h000018);
        go(24'h000018);
        wait_done(256 + 5*256 + 6*8 + 8);
        for (int n = 0; n < 8; n++) pt_mem[n] = ct_mem[n];
        for (int n = 0; n < 8; n++) exp_q.push_back({8'(n), orig[n]});
        go(24'h000018);
        wait_done(256 + 5*256 + 6*8 + 8);

        // Short messages
        for (int l = 0; l < 2; l++) begin
            pt_mem[0] = 8'(l);
            exp_q.push_back({8'h00, 8'(l)});
            go(24'hC0FFEE);
            wait_done(256 + 5*256 + 14);
        end

        // Reset mid-KSA, then rerun the known vector
        load_key_vec();
        go(24'h123456);
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_rdy", int'(rdy), 1);
        chk("midrst_ct_wren", int'(ct_wren), 0);
        @(posedge clk); #1 rst = 1'b0;
        push_key_vec();
        go(24'h4B6579);
        wait_done(256 + 5*256 + 6*10 + 8);

        // en while busy is ignored
        push_key_vec();
        go(24'h4B6579);
        repeat (50) @(posedge clk);
        #1 key = 24'hDEAD01; en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
        wait_done(256 + 5*256 + 6*10 + 8);

        // Back-to-back: second en on the first rdy cycle
        push_key_vec();
        go(24'h4B6579);
        wait_done(256 + 5*256 + 6*10 + 8);
        model(24'h000018);
        go(24'h000018);
        wait_done(256 + 5*256 + 6*10 + 8);

        // Max length
        pt_mem[0] = 8'hFF;
        for (int n = 1; n < 255; n++) pt_mem[n] = 8'(n - 1);
        rk = 24'($urandom);
        model(rk);
        chk("maxlen_last_addr", int'(exp_q[$][15:8]), 8'hFE);
        go(rk);
        wait_done(256 + 5*256 + 6*255 + 8);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule
